// File: rtl/win_overlay_ctrl_pkg.sv
// Shared types and helpers for the win-screen overlay: colour struct, sequencer states, banner colour, dimming.
package win_overlay_ctrl_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        WIPE  = 2'd1,
        BLINK = 2'd2
    } overlay_state_e;

    localparam logic [23:0] TEXT_RGB_DEFAULT = 24'hFFD700;

    // Half-brightness background behind the banner.
    function automatic rgb_t dim(input rgb_t c);
        rgb_t d;
        d.r = {1'b0, c.r[7:1]};
        d.g = {1'b0, c.g[7:1]};
        d.b = {1'b0, c.b[7:1]};
        return d;
    endfunction

endpackage

// File: rtl/win_overlay_ctrl_frame_sequencer.sv
// Frame-rate sequencer for the win overlay: PLAY -> WIPE -> BLINK, left only by restart.
// Every state update happens on a frame_start cycle so the pixel path never sees a mid-frame change.
module win_frame_sequencer
    import win_overlay_ctrl_pkg::*;
#(
    parameter int H_ACTIVE     = 640,
    parameter int WIPE_STEP    = 16,
    parameter int BLINK_FRAMES = 30,
    parameter int WC_W         = $clog2(H_ACTIVE + 1),
    parameter int BC_W         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_start_i,
    input  logic                game_won_i,
    input  logic                restart_i,
    output overlay_state_e      state_o,
    output logic [WC_W-1:0]     wipe_col_o,
    output logic                text_on_o,
    output logic                overlay_active_o
);

    overlay_state_e    state_q;
    logic [WC_W-1:0]   wipe_col_q;
    logic [BC_W-1:0]   blink_cnt_q;
    logic              text_on_q;
    logic              restart_pend_q;
    logic              overlay_active_q;

    logic [WC_W:0]     wipe_sum;
    logic [WC_W-1:0]   wipe_col_d;

    // One extra bit keeps the sum from wrapping before it is clamped.
    assign wipe_sum   = {1'b0, wipe_col_q} + (WC_W+1)'(WIPE_STEP);
    assign wipe_col_d = (wipe_sum >= (WC_W+1)'(H_ACTIVE)) ? WC_W'(H_ACTIVE)
                                                          : wipe_sum[WC_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= PLAY;
            wipe_col_q       <= '0;
            blink_cnt_q      <= '0;
            text_on_q        <= 1'b1;
            restart_pend_q   <= 1'b0;
            overlay_active_q <= 1'b0;
        end else if (frame_start_i) begin
            if (restart_pend_q || restart_i) begin
                state_q          <= PLAY;
                wipe_col_q       <= '0;
                blink_cnt_q      <= '0;
                text_on_q        <= 1'b1;
                restart_pend_q   <= 1'b0;
                overlay_active_q <= 1'b0;
            end else begin
                case (state_q)
                    PLAY: begin
                        if (game_won_i) begin
                            state_q          <= WIPE;
                            wipe_col_q       <= WC_W'(WIPE_STEP);
                            overlay_active_q <= 1'b1;
                        end
                    end
                    WIPE: begin
                        wipe_col_q <= wipe_col_d;
                        if (wipe_col_q >= WC_W'(H_ACTIVE)) begin
                            state_q     <= BLINK;
                            blink_cnt_q <= '0;
                        end
                    end
                    BLINK: begin
                        if (blink_cnt_q == BC_W'(BLINK_FRAMES - 1)) begin
                            blink_cnt_q <= '0;
                            text_on_q   <= ~text_on_q;
                        end else begin
                            blink_cnt_q <= blink_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= PLAY;
                    end
                endcase
            end
        end else if (restart_i) begin
            restart_pend_q <= 1'b1;
        end
    end

    assign state_o          = state_q;
    assign wipe_col_o       = wipe_col_q;
    assign text_on_o        = text_on_q;
    assign overlay_active_o = overlay_active_q;

endmodule

// File: rtl/win_overlay_ctrl.sv
// Final pixel colour stage for the win screen: one-cycle registered mux of maze, dimmed maze and banner.
// Optional border around the screen during the overlay: define WIN_OVERLAY_BORDER_EN.
module win_overlay_ctrl
    import win_overlay_ctrl_pkg::*;
#(
    parameter int          H_ACTIVE     = 640,
    parameter int          WIPE_STEP    = 16,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [23:0] TEXT_RGB     = TEXT_RGB_DEFAULT,
    parameter int          BORDER_W     = 8,
    parameter int          V_ACTIVE     = 480
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pix_valid,
    input  logic        frame_start,
    input  logic [31:0] row,
    input  logic [31:0] col,
    input  logic        iswin,
    input  logic [23:0] maze_rgb,
    input  logic        game_won,
    input  logic        restart,
    output logic [23:0] rgb_out,
    output logic        rgb_valid,
    output logic        overlay_active
);

    localparam int WC_W = $clog2(H_ACTIVE + 1);

    overlay_state_e  state;
    logic [WC_W-1:0] wipe_col;
    logic            text_on;
    logic            border_hit;
    rgb_t            bg;
    logic [23:0]     rgb_d;
    logic [23:0]     rgb_q;
    logic            rgb_valid_q;

    win_frame_sequencer #(
        .H_ACTIVE     (H_ACTIVE),
        .WIPE_STEP    (WIPE_STEP),
        .BLINK_FRAMES (BLINK_FRAMES),
        .WC_W         (WC_W)
    ) u_seq (
        .clk              (clk),
        .rst_n            (reset_n),
        .frame_start_i    (frame_start),
        .game_won_i       (game_won),
        .restart_i        (restart),
        .state_o          (state),
        .wipe_col_o       (wipe_col),
        .text_on_o        (text_on),
        .overlay_active_o (overlay_active)
    );

`ifdef WIN_OVERLAY_BORDER_EN
    assign border_hit = (row < 32'(BORDER_W)) ||
                        (row >= 32'(V_ACTIVE - BORDER_W)) ||
                        (col < 32'(BORDER_W)) ||
                        (col >= 32'(H_ACTIVE - BORDER_W));
`else
    logic unused_row;
    assign unused_row = ^row;
    assign border_hit = 1'b0;
`endif

    assign bg = dim(rgb_t'(maze_rgb));

    always_comb begin
        rgb_d = '0;
        if (pix_valid) begin
            case (state)
                WIPE: begin
                    if (border_hit || (iswin && (col < 32'(wipe_col))))
                        rgb_d = TEXT_RGB;
                    else
                        rgb_d = bg;
                end
                BLINK: begin
                    if (border_hit || (iswin && text_on))
                        rgb_d = TEXT_RGB;
                    else
                        rgb_d = bg;
                end
                default: rgb_d = maze_rgb;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q       <= '0;
            rgb_valid_q <= 1'b0;
        end else begin
            rgb_q       <= rgb_d;
            rgb_valid_q <= pix_valid;
        end
    end

    assign rgb_out   = rgb_q;
    assign rgb_valid = rgb_valid_q;

endmodule

// File: tb/tb_win_overlay_ctrl.sv
// Directed bench for win_overlay_ctrl: vector tables for pixel colours plus hand-written frame sequences.
module tb_win_overlay_ctrl;

    localparam logic [23:0] TEXT = 24'hFFD700;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pix_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic [31:0] row = '0;
    logic [31:0] col = '0;
    logic        iswin = 1'b0;
    logic [23:0] maze_rgb = '0;
    logic        game_won = 1'b0;
    logic        restart = 1'b0;
    logic [23:0] rgb_out;
    logic        rgb_valid;
    logic        overlay_active;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic        pv;
        logic [31:0] r;
        logic [31:0] c;
        logic        win;
        logic [23:0] maze;
        logic [23:0] exp_rgb;
        logic        exp_vld;
    } vec_t;

    vec_t play_tab[3];
    vec_t wipe_tab[8];

    win_overlay_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pix_valid      (pix_valid),
        .frame_start    (frame_start),
        .row            (row),
        .col            (col),
        .iswin          (iswin),
        .maze_rgb       (maze_rgb),
        .game_won       (game_won),
        .restart        (restart),
        .rgb_out        (rgb_out),
        .rgb_valid      (rgb_valid),
        .overlay_active (overlay_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        pix_valid = v.pv;
        row       = v.r;
        col       = v.c;
        iswin     = v.win;
        maze_rgb  = v.maze;
        @(negedge clk);
        pix_valid = 1'b0;
        iswin     = 1'b0;
        check({v.name, "_rgb"}, 32'(rgb_out), 32'(v.exp_rgb));
        check({v.name, "_vld"}, 32'(rgb_valid), 32'(v.exp_vld));
    endtask

    task automatic pix(input string name, input logic [31:0] c, input logic w,
                       input logic [23:0] m, input logic [23:0] exp);
        vec_t v;
        v.name = name; v.pv = 1'b1; v.r = 32'd240; v.c = c; v.win = w;
        v.maze = m; v.exp_rgb = exp; v.exp_vld = 1'b1;
        apply(v);
    endtask

    task automatic fstart();
        @(negedge clk);
        pix_valid   = 1'b0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    initial begin
        logic [23:0] border_exp;
`ifdef WIN_OVERLAY_BORDER_EN
        border_exp = TEXT;
`else
        border_exp = 24'h404040;
`endif
        play_tab[0] = '{"play_basic", 1'b1, 32'd10, 32'd100, 1'b0, 24'h123456, 24'h123456, 1'b1};
        play_tab[1] = '{"play_novld", 1'b0, 32'd10, 32'd100, 1'b1, 24'h123456, 24'h000000, 1'b0};
        play_tab[2] = '{"play_iswin", 1'b1, 32'd10, 32'd100, 1'b1, 24'hABCDEF, 24'hABCDEF, 1'b1};

        wipe_tab[0] = '{"wipe_c10",    1'b1, 32'd240, 32'd10,  1'b1, 24'h808080, TEXT,       1'b1};
        wipe_tab[1] = '{"wipe_c20",    1'b1, 32'd240, 32'd20,  1'b1, 24'h808080, 24'h404040, 1'b1};
        wipe_tab[2] = '{"wipe_nowin",  1'b1, 32'd240, 32'd10,  1'b0, 24'h808080, 24'h404040, 1'b1};
        wipe_tab[3] = '{"wipe_novld",  1'b0, 32'd240, 32'd10,  1'b1, 24'h808080, 24'h000000, 1'b0};
        wipe_tab[4] = '{"wipe_c15",    1'b1, 32'd240, 32'd15,  1'b1, 24'hFEFEFE, TEXT,       1'b1};
        wipe_tab[5] = '{"wipe_c16",    1'b1, 32'd240, 32'd16,  1'b1, 24'hFF8001, 24'h7F4000, 1'b1};
        wipe_tab[6] = '{"wipe_border", 1'b1, 32'd3,   32'd300, 1'b0, 24'h808080, border_exp, 1'b1};
        wipe_tab[7] = '{"wipe_bleft",  1'b1, 32'd100, 32'd2,   1'b0, 24'h808080, border_exp, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rgb", 32'(rgb_out), 32'h0);
        check("rst_vld", 32'(rgb_valid), 32'h0);
        check("rst_ovl", 32'(overlay_active), 32'h0);
        reset_n = 1'b1;

        foreach (play_tab[i]) apply(play_tab[i]);
        check("play_ovl", 32'(overlay_active), 32'h0);

        // Enter WIPE: frame 1 has wipe_col = 16
        game_won = 1'b1;
        fstart();
        @(negedge clk);
        check("wipe_ovl", 32'(overlay_active), 32'h1);
        foreach (wipe_tab[i]) apply(wipe_tab[i]);

        // game_won dropping is ignored; 39 frame_starts in total -> wipe_col = 624
        game_won = 1'b0;
        for (int i = 0; i < 38; i++) fstart();
        pix("wipe39_c620", 32'd620, 1'b1, 24'h808080, TEXT);
        pix("wipe39_c630", 32'd630, 1'b1, 24'h808080, 24'h404040);
        fstart();
        pix("wipe40_c639", 32'd639, 1'b1, 24'h808080, TEXT);
        check("wipe40_ovl", 32'(overlay_active), 32'h1);

        // 41st frame_start enters BLINK with text on
        fstart();
        pix("blink0", 32'd100, 1'b1, 24'h808080, TEXT);
        pix("blink0_nowin", 32'd100, 1'b0, 24'h808080, 24'h404040);
        for (int i = 0; i < 29; i++) fstart();
        pix("blink29_on", 32'd100, 1'b1, 24'h808080, TEXT);
        fstart();
        pix("blink30_off", 32'd100, 1'b1, 24'h808080, 24'h404040);
        check("blink_ovl", 32'(overlay_active), 32'h1);
        for (int i = 0; i < 29; i++) fstart();
        pix("blink59_off", 32'd100, 1'b1, 24'h808080, 24'h404040);
        fstart();
        pix("blink60_on", 32'd100, 1'b1, 24'h808080, TEXT);

        // Restart mid-frame: rest of the frame stays BLINK
        pulse_restart();
        pix("rst_midframe", 32'd100, 1'b1, 24'h808080, TEXT);
        check("rst_mid_ovl", 32'(overlay_active), 32'h1);
        fstart();
        pix("after_restart", 32'd100, 1'b1, 24'h123456, 24'h123456);
        check("after_rst_ovl", 32'(overlay_active), 32'h0);

        // Pending restart beats game_won on the same frame_start
        pulse_restart();
        game_won = 1'b1;
        fstart();
        pix("rst_wins", 32'd5, 1'b1, 24'h808080, 24'h808080);
        check("rst_wins_ovl", 32'(overlay_active), 32'h0);
        fstart();
        pix("wipe_after", 32'd5, 1'b1, 24'h808080, TEXT);
        check("wipe_after_ovl", 32'(overlay_active), 32'h1);

        // Asynchronous reset mid-frame clears outputs at once
        game_won = 1'b0;
        @(negedge clk);
        pix_valid = 1'b1; col = 32'd5; iswin = 1'b1; maze_rgb = 24'h808080;
        @(negedge clk);
        check("pre_reset_rgb", 32'(rgb_out), 32'(TEXT));
        reset_n = 1'b0;
        #1;
        check("async_rst_rgb", 32'(rgb_out), 32'h0);
        check("async_rst_vld", 32'(rgb_valid), 32'h0);
        check("async_rst_ovl", 32'(overlay_active), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        pix_valid = 1'b0; iswin = 1'b0;
        pix("post_reset_play", 32'd5, 1'b1, 24'h123456, 24'h123456);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
